// File: rtl/instr_fetch_dispatch.sv
// -----------------------------------------------------------------------------
// instr_fetch_dispatch
// Front-end sequencer: fetches one instruction word, latches it into IR,
// holds it while the per-opcode execute FSMs work, waits for their done pulse,
// then flushes IR to a bubble so every execute FSM drops back to idle.
// A missing done pulse ends in a sticky FAULT; a HALT opcode ends in a sticky
// HALTED state. Both states are left only through rst.
// -----------------------------------------------------------------------------
module instr_fetch_dispatch #(
   parameter int              IW           = 16,
   parameter logic [3:0]      HALT_OP      = 4'hF,
   parameter logic [IW-1:0]   BUBBLE       = 16'hF000,
   parameter int              DONE_TIMEOUT = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic [IW-1:0] mem_data,
   input  logic          mem_ready,
   input  logic          done,
   output logic          pc_out,
   output logic          mem_rd,
   output logic          ir_in,
   output logic [IW-1:0] ir,
   output logic          busy,
   output logic          halted,
   output logic          fault,
   output logic [15:0]   retired
);

   // Last timer value tolerated in EXEC before the done wait is abandoned.
   localparam logic [7:0] TIMEOUT_LAST = 8'(DONE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH_A = 3'd1,
      ST_FETCH_W = 3'd2,
      ST_LOAD    = 3'd3,
      ST_EXEC    = 3'd4,
      ST_FLUSH   = 3'd5,
      ST_HALTED  = 3'd6,
      ST_FAULT   = 3'd7
   } state_e;

   state_e          state_q,  state_d;
   logic [IW-1:0]   ir_q,     ir_d;
   logic [7:0]      timer_q,  timer_d;
   logic [15:0]     retired_q, retired_d;
   logic            done_q;
   logic            done_rise_s;

   logic            pc_out_q;
   logic            mem_rd_q;
   logic            ir_in_q;
   logic            busy_q;
   logic            halted_q;
   logic            fault_q;

   // A done level that was already high on the previous cycle is not a new
   // completion; this makes a multi-cycle done pulse count exactly once.
   assign done_rise_s = done & ~done_q;

   // Next-state, IR, timer and retire-count logic.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      timer_d   = timer_q;
      retired_d = retired_q;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH_A;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH_A: begin
            state_d = ST_FETCH_W;
         end
         ST_FETCH_W: begin
            // No memory timeout: the read strobe stays up until memory answers.
            if (mem_ready) begin
               state_d = ST_LOAD;
               ir_d    = mem_data;
            end else begin
               state_d = ST_FETCH_W;
            end
         end
         ST_LOAD: begin
            if (ir_q[IW-1 -: 4] == HALT_OP) begin
               state_d = ST_HALTED;
               ir_d    = BUBBLE;
            end else begin
               state_d = ST_EXEC;
               timer_d = 8'd0;
            end
         end
         ST_EXEC: begin
            timer_d = timer_q + 8'd1;
            // A completion arriving on the last allowed cycle still retires.
            if (done_rise_s) begin
               state_d   = ST_FLUSH;
               ir_d      = BUBBLE;
               retired_d = retired_q + 16'd1;
            end else if (timer_q == TIMEOUT_LAST) begin
               state_d = ST_FAULT;
               ir_d    = BUBBLE;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_FLUSH: begin
            ir_d = BUBBLE;
            if (run) begin
               state_d = ST_FETCH_A;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
            ir_d    = BUBBLE;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
            ir_d    = BUBBLE;
         end
         default: begin
            state_d = ST_IDLE;
            ir_d    = BUBBLE;
         end
      endcase
   end

   // State, datapath and output registers; outputs are decoded from the next
   // state so they line up with the state they describe with no input-to-output path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ir_q      <= BUBBLE;
         timer_q   <= 8'd0;
         retired_q <= 16'd0;
         done_q    <= 1'b0;
         pc_out_q  <= 1'b0;
         mem_rd_q  <= 1'b0;
         ir_in_q   <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         timer_q   <= timer_d;
         retired_q <= retired_d;
         done_q    <= done;
         pc_out_q  <= (state_d == ST_FETCH_A);
         mem_rd_q  <= (state_d == ST_FETCH_A) || (state_d == ST_FETCH_W);
         ir_in_q   <= (state_d == ST_LOAD);
         busy_q    <= (state_d != ST_IDLE) && (state_d != ST_HALTED) &&
                      (state_d != ST_FAULT);
         halted_q  <= (state_d == ST_HALTED);
         fault_q   <= (state_d == ST_FAULT);
      end
   end

   assign pc_out  = pc_out_q;
   assign mem_rd  = mem_rd_q;
   assign ir_in   = ir_in_q;
   assign ir      = ir_q;
   assign busy    = busy_q;
   assign halted  = halted_q;
   assign fault   = fault_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// -----------------------------------------------------------------------------
// Directed bench for instr_fetch_dispatch. Inputs change and outputs are
// sampled on the falling clock edge; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_instr_fetch_dispatch;

   logic        clk;
   logic        rst;
   logic        run;
   logic [15:0] mem_data;
   logic        mem_ready;
   logic        done;
   logic        pc_out;
   logic        mem_rd;
   logic        ir_in;
   logic [15:0] ir;
   logic        busy;
   logic        halted;
   logic        fault;
   logic [15:0] retired;

   int n_checks;
   int n_errors;
   int rd_cycles;

   instr_fetch_dispatch #(
      .IW           (16),
      .HALT_OP      (4'hF),
      .BUBBLE       (16'hF000),
      .DONE_TIMEOUT (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .done      (done),
      .pc_out    (pc_out),
      .mem_rd    (mem_rd),
      .ir_in     (ir_in),
      .ir        (ir),
      .busy      (busy),
      .halted    (halted),
      .fault     (fault),
      .retired   (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      run       = 1'b0;
      mem_ready = 1'b0;
      mem_data  = 16'h0000;
      done      = 1'b0;
      tick();
      tick();

      // Reset state
      check_value("rst_ir", 32'(ir), 32'h0000_F000);
      check_value("rst_retired", 32'(retired), 32'h0);
      check_value("rst_flags", 32'({pc_out, mem_rd, ir_in, busy, halted, fault}), 32'h0);

      // Basic MOVI instruction, immediate memory
      rst = 1'b0;
      run = 1'b1;
      tick();                                   // FETCH_A
      check_value("t1_fetch_a", 32'({pc_out, mem_rd, busy}), 32'h7);
      mem_ready = 1'b1;
      mem_data  = 16'h7081;
      tick();                                   // FETCH_W
      check_value("t1_fetch_w", 32'({pc_out, mem_rd, ir_in}), 32'h2);
      tick();                                   // LOAD
      check_value("t1_load_strobe", 32'(ir_in), 32'h1);
      check_value("t1_load_ir", 32'(ir), 32'h0000_7081);
      mem_ready = 1'b0;
      mem_data  = 16'hDEAD;
      tick();                                   // EXEC, timer 0
      check_value("t1_exec_ir", 32'(ir), 32'h0000_7081);
      check_value("t1_exec_flags", 32'({ir_in, busy}), 32'h1);
      tick();                                   // EXEC, timer 1
      done = 1'b1;
      tick();                                   // FLUSH
      check_value("t1_flush_ir", 32'(ir), 32'h0000_F000);
      check_value("t1_retired", 32'(retired), 32'h1);
      check_value("t1_flush_pc", 32'(pc_out), 32'h0);
      tick();                                   // FETCH_A of next word
      done = 1'b0;
      check_value("t1_next_pc", 32'(pc_out), 32'h1);

      // Slow memory: four FETCH_W cycles, mem_rd high five cycles total
      rd_cycles = 0;
      if (mem_rd) rd_cycles++;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (mem_rd) rd_cycles++;
         if (i == 2) check_value("t2_ir_hold", 32'(ir), 32'h0000_F000);
         if (i == 3) begin
            mem_ready = 1'b1;
            mem_data  = 16'h1234;
         end
      end
      tick();                                   // LOAD
      if (mem_rd) rd_cycles++;
      check_value("t2_rd_cycles", 32'(rd_cycles), 32'd5);
      check_value("t2_load_ir", 32'(ir), 32'h0000_1234);
      check_value("t2_load_strobe", 32'(ir_in), 32'h1);
      mem_ready = 1'b0;
      done      = 1'b1;                         // level already high at EXEC entry
      tick();                                   // EXEC
      check_value("t2_strobe_single", 32'({ir_in, busy}), 32'h1);
      tick();                                   // still EXEC: held level is no rise
      check_value("t2_no_false_rise", 32'(retired), 32'h1);
      check_value("t2_exec_ir", 32'(ir), 32'h0000_1234);
      done = 1'b0;
      run  = 1'b0;                              // drop run mid-instruction
      tick();
      done = 1'b1;
      tick();                                   // FLUSH
      check_value("t5_retire_after_stop", 32'(retired), 32'h2);
      done = 1'b0;
      tick();                                   // IDLE
      check_value("t5_idle_busy", 32'(busy), 32'h0);
      tick();
      tick();
      check_value("t5_idle_quiet", 32'({pc_out, mem_rd, busy}), 32'h0);
      run = 1'b1;
      tick();                                   // FETCH_A
      check_value("t5_restart_pc", 32'(pc_out), 32'h1);

      // Done never arrives: fault 32 cycles after EXEC entry
      mem_ready = 1'b1;
      mem_data  = 16'h2345;
      tick();                                   // FETCH_W
      tick();                                   // LOAD
      check_value("t4_load_strobe", 32'(ir_in), 32'h1);
      mem_ready = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         tick();
         if (k == 32) check_value("t4_no_fault_early", 32'({fault, busy}), 32'h1);
         if (k == 33) begin
            check_value("t4_fault", 32'({fault, busy}), 32'h2);
            check_value("t4_fault_ir", 32'(ir), 32'h0000_F000);
            check_value("t4_fault_retired", 32'(retired), 32'h2);
         end
      end
      tick();
      tick();
      check_value("t4_fault_sticky", 32'({fault, mem_rd}), 32'h2);
      rst = 1'b1;
      #1;
      check_value("t4_rst_clears", 32'({fault, retired}), 32'h0);
      tick();
      rst = 1'b0;

      // HALT opcode
      tick();                                   // FETCH_A
      mem_ready = 1'b1;
      mem_data  = 16'hF000;
      tick();                                   // FETCH_W
      tick();                                   // LOAD
      mem_ready = 1'b0;
      tick();                                   // HALTED
      check_value("t3_halted", 32'({halted, busy}), 32'h2);
      check_value("t3_halt_ir", 32'(ir), 32'h0000_F000);
      rd_cycles = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (mem_rd) rd_cycles++;
      end
      check_value("t3_no_fetch", 32'(rd_cycles), 32'd0);
      check_value("t3_halt_sticky", 32'(halted), 32'h1);
      rst = 1'b1;
      #1;
      check_value("t3_rst_clears", 32'(halted), 32'h0);
      tick();
      rst = 1'b0;

      // Retire counter wrap
      tick();                                   // FETCH_A
      mem_ready = 1'b1;
      mem_data  = 16'h3000;
      tick();
      tick();                                   // LOAD
      mem_ready = 1'b0;
      tick();                                   // EXEC
      force dut.retired_q = 16'hFFFF;
      tick();
      release dut.retired_q;
      check_value("t6_preload", 32'(retired), 32'h0000_FFFF);
      done = 1'b1;
      tick();                                   // FLUSH
      check_value("t6_wrap", 32'(retired), 32'h0);
      check_value("t6_wrap_ir", 32'(ir), 32'h0000_F000);
      done = 1'b0;

      // Reset asserted during EXEC
      tick();                                   // FETCH_A
      mem_ready = 1'b1;
      mem_data  = 16'h7081;
      tick();
      tick();                                   // LOAD
      mem_ready = 1'b0;
      tick();                                   // EXEC
      check_value("t6_exec_before_rst", 32'({busy, ir}), 32'h0001_7081);
      #2;
      rst = 1'b1;
      #1;
      check_value("t6_rst_flags", 32'({pc_out, mem_rd, ir_in, busy, halted, fault}), 32'h0);
      check_value("t6_rst_ir", 32'(ir), 32'h0000_F000);
      tick();
      rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
